// File: rtl/seg_pkg.sv
// Shared definitions for the segment-pattern decoder: segment encodings,
// bus widths and the debounce FSM state type.
package seg_pkg;

    localparam int DIGIT_W = 4;
    localparam int SEG_W   = 7;

    // Bit order {g,f,e,d,c,b,a}, active-high.
    localparam logic [SEG_W-1:0] SEG_0     = 7'h3F;
    localparam logic [SEG_W-1:0] SEG_1     = 7'h06;
    localparam logic [SEG_W-1:0] SEG_2     = 7'h5B;
    localparam logic [SEG_W-1:0] SEG_3     = 7'h4F;
    localparam logic [SEG_W-1:0] SEG_4     = 7'h66;
    localparam logic [SEG_W-1:0] SEG_5     = 7'h6D;
    localparam logic [SEG_W-1:0] SEG_6     = 7'h7D;
    localparam logic [SEG_W-1:0] SEG_7     = 7'h07;
    localparam logic [SEG_W-1:0] SEG_8     = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_9     = 7'h6F;
    localparam logic [SEG_W-1:0] SEG_A     = 7'h77;
    localparam logic [SEG_W-1:0] SEG_B     = 7'h7C;
    localparam logic [SEG_W-1:0] SEG_C     = 7'h39;
    localparam logic [SEG_W-1:0] SEG_D     = 7'h5E;
    localparam logic [SEG_W-1:0] SEG_E     = 7'h79;
    localparam logic [SEG_W-1:0] SEG_F     = 7'h71;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

    typedef enum logic {
        IDLE,
        COUNT
    } seg_state_t;

    // Forward table: digit -> segment pattern.
    function automatic logic [SEG_W-1:0] seg_of(input logic [DIGIT_W-1:0] digit);
        logic [SEG_W-1:0] pattern;
        case (digit)
            4'h0:    pattern = SEG_0;
            4'h1:    pattern = SEG_1;
            4'h2:    pattern = SEG_2;
            4'h3:    pattern = SEG_3;
            4'h4:    pattern = SEG_4;
            4'h5:    pattern = SEG_5;
            4'h6:    pattern = SEG_6;
            4'h7:    pattern = SEG_7;
            4'h8:    pattern = SEG_8;
            4'h9:    pattern = SEG_9;
            4'hA:    pattern = SEG_A;
            4'hB:    pattern = SEG_B;
            4'hC:    pattern = SEG_C;
            4'hD:    pattern = SEG_D;
            4'hE:    pattern = SEG_E;
            default: pattern = SEG_F;
        endcase
        return pattern;
    endfunction

endpackage

// File: rtl/seg_encoder.sv
// Combinational inverse of the seven-segment table: pattern -> hex digit,
// with flags for a recognised digit and for the all-off blank pattern.
module seg_encoder
    import seg_pkg::*;
(
    input  logic [SEG_W-1:0]   pattern,
    output logic [DIGIT_W-1:0] digit,
    output logic               is_digit,
    output logic               is_blank
);

    logic [15:0] match;

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_match
            assign match[gi] = (pattern == seg_of(DIGIT_W'(gi)));
        end
    endgenerate

    // Table entries are unique, so at most one match bit is set and OR-ing is safe.
    always_comb begin
        digit = '0;
        for (int i = 0; i < 16; i++) begin
            if (match[i]) begin
                digit = digit | DIGIT_W'(i);
            end
        end
    end

    assign is_digit = |match;
    assign is_blank = (pattern == SEG_BLANK);

endmodule

// File: rtl/seg_pattern_decoder.sv
// Debounces a 7-segment bus, classifies the stable pattern and hands
// recovered digits to a consumer through a valid/ready hold register.
module seg_pattern_decoder
    import seg_pkg::*;
#(
    parameter int N             = 4,
    parameter int M             = 7,
    parameter int STABLE_CYCLES = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [M-1:0] seg,
    input  logic         out_ready,
    output logic [N-1:0] d,
    output logic         out_valid,
    output logic         err,
    output logic         overrun
);

    localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);

    seg_state_t   state_reg, state_next;
    logic [M-1:0] seg_q_reg, seg_q_next;
    logic [7:0]   cnt_reg, cnt_next;
    logic [N-1:0] d_reg, d_next;
    logic         valid_reg, valid_next;
    logic         err_reg, err_next;
    logic         overrun_reg, overrun_next;
    logic         resolve;

    logic [N-1:0] enc_digit;
    logic         enc_is_digit;
    logic         enc_is_blank;

    seg_encoder u_encoder (
        .pattern  (seg_q_reg),
        .digit    (enc_digit),
        .is_digit (enc_is_digit),
        .is_blank (enc_is_blank)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= IDLE;
            seg_q_reg   <= SEG_BLANK;
            cnt_reg     <= '0;
            d_reg       <= '0;
            valid_reg   <= 1'b0;
            err_reg     <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            seg_q_reg   <= seg_q_next;
            cnt_reg     <= cnt_next;
            d_reg       <= d_next;
            valid_reg   <= valid_next;
            err_reg     <= err_next;
            overrun_reg <= overrun_next;
        end
    end

    // Debounce: any change restarts the count; seg_q is resolved once it
    // has been seen STABLE_CYCLES further enabled samples after capture.
    always_comb begin
        state_next = state_reg;
        seg_q_next = seg_q_reg;
        cnt_next   = cnt_reg;
        resolve    = 1'b0;
        if (en) begin
            unique case (state_reg)
                IDLE: begin
                    if (seg != seg_q_reg) begin
                        seg_q_next = seg;
                        cnt_next   = '0;
                        state_next = COUNT;
                    end
                end
                COUNT: begin
                    if (seg != seg_q_reg) begin
                        seg_q_next = seg;
                        cnt_next   = '0;
                    end else if (cnt_reg == CNT_LAST) begin
                        resolve    = 1'b1;
                        state_next = IDLE;
                    end else begin
                        cnt_next = cnt_reg + 8'd1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Hold register: a resolving digit may replace one being consumed this
    // cycle, but never overwrites an unconsumed one.
    always_comb begin
        d_next       = d_reg;
        valid_next   = valid_reg;
        err_next     = 1'b0;
        overrun_next = overrun_reg;
        if (valid_reg && out_ready) begin
            valid_next = 1'b0;
        end
        if (resolve) begin
            if (enc_is_digit) begin
                if (!valid_reg || out_ready) begin
                    d_next     = enc_digit;
                    valid_next = 1'b1;
                end else begin
                    overrun_next = 1'b1;
                end
            end else if (!enc_is_blank) begin
                err_next = 1'b1;
            end
        end
    end

    assign d         = d_reg;
    assign out_valid = valid_reg;
    assign err       = err_reg;
    assign overrun   = overrun_reg;

endmodule

// File: tb/tb_seg_pattern_decoder.sv
// Self-checking bench: directed scenarios plus randomized traffic, compared
// every cycle against a history-based behavioural model.
module tb_seg_pattern_decoder;

    localparam int S = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b0;
    logic [6:0] seg = 7'h00;
    logic       out_ready = 1'b0;
    logic [3:0] d;
    logic       out_valid;
    logic       err;
    logic       overrun;

    int errors = 0;
    int checks = 0;

    localparam logic [6:0] TBL [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    seg_pattern_decoder #(.N(4), .M(7), .STABLE_CYCLES(S)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .seg       (seg),
        .out_ready (out_ready),
        .d         (d),
        .out_valid (out_valid),
        .err       (err),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Model: the enabled-sample history since reset (seeded with the blank
    // reset value). A pattern resolves when it has been the last S+1 samples
    // and the sample before those was different.
    logic [6:0] hist[$];
    logic [3:0] m_d;
    logic       m_valid, m_err, m_overrun;

    function automatic int lookup(input logic [6:0] p);
        for (int i = 0; i < 16; i++) if (TBL[i] == p) return i;
        return -1;
    endfunction

    task automatic model_reset();
        hist.delete();
        hist.push_back(7'h00);
        m_d = 4'h0; m_valid = 1'b0; m_err = 1'b0; m_overrun = 1'b0;
    endtask

    task automatic model_step();
        logic       res;
        logic       v0;
        logic [6:0] pat;
        int         idx;
        res = 1'b0;
        pat = 7'h00;
        if (en) begin
            hist.push_back(seg);
            if (hist.size() > S + 2) hist.delete(0);
            if (hist.size() == S + 2) begin
                pat = hist[S+1];
                res = (hist[0] != pat);
                for (int i = 1; i <= S; i++) if (hist[i] != pat) res = 1'b0;
            end
        end
        v0 = m_valid;
        m_err = 1'b0;
        if (v0 && out_ready) m_valid = 1'b0;
        if (res) begin
            idx = lookup(pat);
            if (idx >= 0) begin
                if (!v0 || out_ready) begin
                    m_d = 4'(idx);
                    m_valid = 1'b1;
                end else begin
                    m_overrun = 1'b1;
                end
            end else if (pat != 7'h00) begin
                m_err = 1'b1;
            end
        end
    endtask

    initial model_reset();

    // Compare process: update model at each edge, check DUT just after it.
    always @(posedge clk) begin
        if (!reset) model_reset();
        else model_step();
        #1;
        check("d", int'(d), int'(m_d));
        check("out_valid", int'(out_valid), int'(m_valid));
        check("err", int'(err), int'(m_err));
        check("overrun", int'(overrun), int'(m_overrun));
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int len;
        int pick;
        logic [6:0] p;

        // Reset state
        cyc(2);
        check("reset_d", int'(d), 0);
        check("reset_valid", int'(out_valid), 0);
        check("reset_overrun", int'(overrun), 0);
        reset = 1'b1;
        en = 1'b1;

        // Digit 2: resolves on the 5th edge (capture + 4)
        seg = 7'h5B;
        cyc(4);
        check("t1_not_yet", int'(out_valid), 0);
        cyc(1);
        check("t1_valid", int'(out_valid), 1);
        check("t1_d", int'(d), 2);
        out_ready = 1'b1;
        cyc(1);
        out_ready = 1'b0;
        check("t1_accepted", int'(out_valid), 0);

        // Glitch of 1 for 3 edges, then 3: only 3 emitted
        seg = 7'h06;
        cyc(3);
        seg = 7'h4F;
        cyc(5);
        check("t2_valid", int'(out_valid), 1);
        check("t2_d", int'(d), 3);
        out_ready = 1'b1;
        cyc(1);
        out_ready = 1'b0;

        // Long-held 8: single emit, no re-emit
        seg = 7'h7F;
        cyc(5);
        check("t3_d", int'(d), 8);
        out_ready = 1'b1;
        cyc(20);
        check("t3_no_reemit", int'(out_valid), 0);
        out_ready = 1'b0;

        // Invalid pattern then blank
        seg = 7'h49;
        cyc(5);
        check("t4_err", int'(err), 1);
        check("t4_valid", int'(out_valid), 0);
        check("t4_d_kept", int'(d), 8);
        cyc(1);
        check("t4_err_pulse", int'(err), 0);
        seg = 7'h00;
        cyc(6);
        check("t4_blank_err", int'(err), 0);
        check("t4_blank_valid", int'(out_valid), 0);

        // Overrun, then replace-on-accept
        seg = 7'h77;
        cyc(5);
        seg = 7'h71;
        cyc(5);
        check("t5_d_held", int'(d), 4'hA);
        check("t5_overrun", int'(overrun), 1);
        seg = 7'h39;
        cyc(4);
        out_ready = 1'b1;
        cyc(1);
        out_ready = 1'b0;
        check("t5_replace_d", int'(d), 4'hC);
        check("t5_replace_valid", int'(out_valid), 1);
        out_ready = 1'b1;
        cyc(1);
        out_ready = 1'b0;

        // Reset mid-count, then re-capture after release
        seg = 7'h6D;
        cyc(3);
        #1 reset = 1'b0;
        #1;
        check("t6_rst_valid", int'(out_valid), 0);
        check("t6_rst_d", int'(d), 0);
        check("t6_rst_overrun", int'(overrun), 0);
        cyc(2);
        reset = 1'b1;
        cyc(4);
        check("t6_not_yet", int'(out_valid), 0);
        cyc(1);
        check("t6_d", int'(d), 5);
        out_ready = 1'b1;
        cyc(1);
        out_ready = 1'b0;

        // en low for 3 cycles mid-count delays resolution by 3
        seg = 7'h66;
        cyc(2);
        en = 1'b0;
        cyc(3);
        en = 1'b1;
        cyc(2);
        check("t7_not_yet", int'(out_valid), 0);
        cyc(1);
        check("t7_valid", int'(out_valid), 1);
        check("t7_d", int'(d), 4);
        out_ready = 1'b1;
        cyc(1);

        // Randomized traffic
        for (int run = 0; run < 300; run++) begin
            pick = $urandom_range(0, 99);
            if (pick < 60) p = TBL[$urandom_range(0, 15)];
            else if (pick < 75) p = 7'h00;
            else p = 7'($urandom_range(0, 127));
            seg = p;
            len = $urandom_range(1, 8);
            for (int c = 0; c < len; c++) begin
                en = ($urandom_range(0, 9) != 0);
                out_ready = ($urandom_range(0, 2) == 0);
                cyc(1);
            end
            if ($urandom_range(0, 99) == 0) begin
                #2 reset = 1'b0;
                cyc(2);
                reset = 1'b1;
            end
        end

        cyc(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg_pattern_decoder.md
Name: seg_pattern_decoder

Overview:
- Inverse of the display path: samples a 7-segment pattern bus and recovers the 4-bit hex digit it shows.
- Used for loopback self-test of the display output and for capturing patterns from external segment sources.
- Debounces the input by requiring a stable pattern, classifies it as digit, blank or invalid, and delivers digits through a valid/ready hold register.

Parameters:
- N, 4, digit width (fixed at 4; hex only).
- M, 7, segment bus width; bit order {g,f,e,d,c,b,a}, active-high.
- STABLE_CYCLES, 4, extra consecutive samples required after a change (legal range 1..255).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- en  in  1  sample enable; when low, the debounce FSM and counter freeze.
- seg  in  M  segment pattern to decode.
- out_ready  in  1  consumer accepts d this cycle.
- d  out  N  decoded digit, held while out_valid.
- out_valid  out  1  d holds an unconsumed digit.
- err  out  1  one-cycle pulse when an invalid non-blank pattern resolves.
- overrun  out  1  sticky; a digit was dropped because the hold register was full.

Behaviour:
- Reset (async, reset=0): d=0, out_valid=0, err=0, overrun=0, seg_q=0 (blank), cnt=0, state=IDLE.
- FSM states: IDLE, COUNT. All transitions below occur only when en=1.
- IDLE:
  - If seg != seg_q: seg_q<=seg, cnt<=0, go to COUNT.
  - Otherwise stay in IDLE. A pattern already resolved is never re-emitted.
- COUNT:
  - If seg != seg_q: seg_q<=seg, cnt<=0, stay in COUNT (restart).
  - Else if cnt == STABLE_CYCLES-1: resolve seg_q, go to IDLE.
  - Else: cnt<=cnt+1.
- Latency: a change captured at edge E0 and held stable resolves at edge E(STABLE_CYCLES). out_valid/err are visible after that edge.
- Encoding table:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
  - 00 = blank: resolves silently; no output, no err.
  - Any other pattern = invalid: err=1 for one cycle; d and out_valid unchanged.
- Hold register (each cycle):
  - Accept when out_valid && out_ready: out_valid<=0, unless a digit resolves in the same cycle.
  - Resolve with out_valid=0: d<=digit, out_valid<=1.
  - Resolve with out_valid=1 && out_ready=1: d<=digit, out_valid stays 1; no overrun.
  - Resolve with out_valid=1 && out_ready=0: new digit dropped, overrun<=1; d is unchanged.
- overrun clears only on reset.
- en=0: seg is ignored; state, cnt and seg_q hold. The hold register still honours out_ready. A pending resolve is deferred until en returns.
- Reset asserted mid-COUNT: everything returns to reset values immediately. A pattern still present after reset release is treated as a new change.
- Width rules:
  - cnt is 8 bits and never exceeds STABLE_CYCLES-1.
  - seg comparison is full M bits.

Decomposition:
- Package seg_pkg:
  - SEG_0..SEG_F and SEG_BLANK localparams (M-bit).
  - Enum seg_state_t {IDLE, COUNT}.
- Sub-module seg_encoder: combinational pattern -> {digit[N-1:0], is_digit, is_blank}. This is the exact inverse of the team's seven-segment decoder table.
- Top module: FSM, counter and hold register.

Test Plan:
- Apply seg=7'h5B with en=1 and STABLE_CYCLES=4, stable for 5 edges -> out_valid rises after the 5th edge (capture + 4), d=4'h2. Then out_ready=1 for one cycle -> out_valid=0.
- Hold seg=7'h06 for 3 edges, switch to 7'h4F for 5 edges -> a single out_valid with d=4'h3. No digit 1 is emitted.
- Apply seg=7'h7F, hold it, then keep seg constant for a further 20 edges -> exactly one emit, d=4'h8. out_ready=1 after the first accept produces no second valid.
- Apply seg=7'h49, stable -> err pulses one cycle at resolve; out_valid stays 0; d unchanged. seg=7'h00 -> no err, no valid.
- With out_ready=0, resolve 7'h77 (d=A) then 7'h71 -> d stays 4'hA, overrun=1. Resolve 7'h39 on a cycle with out_ready=1 -> d=4'hC, out_valid stays 1.
- Drop reset low mid-COUNT (seg=7'h6D, cnt=2) -> all outputs 0 immediately. After reset release with seg=7'h6D held -> resolves 4 edges after the capture edge, d=4'h5. Toggle en=0 for 3 cycles mid-count -> resolution delayed by exactly 3 cycles.
